// File: rtl/otter_lsu_pkg.sv
// Shared state encoding, access-size constants and lane helpers for the OTTER load/store unit.
package otter_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0001_0000;

  // Accesses that Memory cannot serve from a single aligned word.
  function automatic logic needs_split(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && (off == 2'd3)) || ((size == SZ_WORD) && (off != 2'd0));
  endfunction

  function automatic logic [2:0] split_count(input logic [1:0] size);
    return (size == SZ_HALF) ? 3'd2 : 3'd4;
  endfunction

  function automatic logic [7:0] byte_lane(input logic [31:0] data, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/otter_lsu_extend.sv
// Combinational sign/zero extension of right-justified load data (sign=1 means unsigned).
module otter_lsu_extend
  import otter_lsu_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_size)
      SZ_BYTE: o_data = {{24{~i_sign & i_data[7]}}, i_data[7:0]};
      SZ_HALF: o_data = {{16{~i_sign & i_data[15]}}, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/otter_lsu.sv
// OTTER load/store unit on Memory port 2; splits misaligned accesses into byte accesses.
// Optional: define OTTER_LSU_MISALIGN_TRAP_EN to reject split-eligible requests with RSP_ERR.
module otter_lsu
  import otter_lsu_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_sign,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_mem_rden2,
  output logic        o_mem_we2,
  output logic [31:0] o_mem_addr2,
  output logic [31:0] o_mem_din2,
  output logic [1:0]  o_mem_size,
  output logic        o_mem_sign,
  input  logic [31:0] i_mem_dout2
);

`ifdef OTTER_LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  lsu_state_t  r_state, w_state_nxt;
  logic [2:0]  r_k, w_k_nxt, r_n, w_n_nxt, w_k_inc;
  logic [31:0] r_addr, w_addr_nxt, r_wdata, w_wdata_nxt, r_asm, w_asm_nxt;
  logic [1:0]  r_size, w_size_nxt;
  logic        r_sign, w_sign_nxt, r_we, w_we_nxt;
  logic        r_split, w_split_nxt, r_err, w_err_nxt;
  logic        w_req_io, w_req_split, w_last;

  logic        r_req_ready, r_rsp_valid, r_rsp_err;
  logic        r_mem_rden2, r_mem_we2, r_mem_sign;
  logic [31:0] r_rsp_data, r_mem_addr2, r_mem_din2;
  logic [1:0]  r_mem_size;

  logic        w_active, w_done_nxt, w_mem_sign_nxt;
  logic [1:0]  w_ext_size, w_mem_size_nxt;
  logic [31:0] w_ext, w_mem_addr_nxt, w_mem_din_nxt, w_rsp_data_nxt;

  // Next-state and request-context logic.
  always_comb begin
    w_req_io    = (i_req_addr >= IO_BASE);
    w_req_split = !w_req_io && needs_split(i_req_size, i_req_addr[1:0]);
    w_k_inc     = r_k + 3'd1;
    w_last      = (w_k_inc == r_n);
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_n_nxt     = r_n;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_asm_nxt   = r_asm;
    w_size_nxt  = r_size;
    w_sign_nxt  = r_sign;
    w_we_nxt    = r_we;
    w_split_nxt = r_split;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_addr_nxt  = i_req_addr;
          w_wdata_nxt = i_req_wdata;
          w_size_nxt  = i_req_size;
          w_sign_nxt  = i_req_sign;
          w_we_nxt    = i_req_we;
          w_split_nxt = w_req_split;
          w_n_nxt     = w_req_split ? split_count(i_req_size) : 3'd1;
          w_k_nxt     = 3'd0;
          w_asm_nxt   = 32'd0;
          if (i_req_size == SZ_ILL) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = DONE;
          end else if (TRAP_EN && w_req_split) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_err_nxt   = 1'b0;
            w_state_nxt = ISSUE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (r_we) begin
          w_k_nxt     = w_k_inc;
          w_state_nxt = w_last ? DONE : ISSUE;
        end else begin
          w_state_nxt = CAPT;
        end
      end
      CAPT: begin
        if (r_split) begin
          case (r_k[1:0])
            2'd0:    w_asm_nxt[7:0]   = i_mem_dout2[7:0];
            2'd1:    w_asm_nxt[15:8]  = i_mem_dout2[7:0];
            2'd2:    w_asm_nxt[23:16] = i_mem_dout2[7:0];
            default: w_asm_nxt[31:24] = i_mem_dout2[7:0];
          endcase
        end else begin
          w_asm_nxt = i_mem_dout2;
        end
        w_k_nxt     = w_k_inc;
        w_state_nxt = w_last ? DONE : ISSUE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Unsplit data arrives already sized by Memory, so only assembled bytes are extended here.
  assign w_ext_size = w_split_nxt ? w_size_nxt : SZ_WORD;

  otter_lsu_extend u_extend (
    .i_data (w_asm_nxt),
    .i_size (w_ext_size),
    .i_sign (w_sign_nxt),
    .o_data (w_ext)
  );

  // Memory-port and response values for the coming cycle; CAPT keeps ISSUE's address/size/sign.
  always_comb begin
    w_active   = (w_state_nxt == ISSUE) || (w_state_nxt == CAPT);
    w_done_nxt = (w_state_nxt == DONE);
    if (w_active) begin
      w_mem_addr_nxt = w_addr_nxt + {29'd0, w_k_nxt};
      if (w_split_nxt) begin
        w_mem_size_nxt = SZ_BYTE;
        w_mem_sign_nxt = 1'b1;
        w_mem_din_nxt  = w_we_nxt ? {24'd0, byte_lane(w_wdata_nxt, w_k_nxt[1:0])} : 32'd0;
      end else begin
        w_mem_size_nxt = w_size_nxt;
        w_mem_sign_nxt = w_sign_nxt;
        w_mem_din_nxt  = w_we_nxt ? w_wdata_nxt : 32'd0;
      end
    end else begin
      w_mem_addr_nxt = 32'd0;
      w_mem_size_nxt = 2'd0;
      w_mem_sign_nxt = 1'b0;
      w_mem_din_nxt  = 32'd0;
    end
    if (w_done_nxt && !w_we_nxt && !w_err_nxt) begin
      w_rsp_data_nxt = w_ext;
    end else begin
      w_rsp_data_nxt = 32'd0;
    end
  end

  // State and request-context registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_k     <= 3'd0;
      r_n     <= 3'd1;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_asm   <= 32'd0;
      r_size  <= 2'd0;
      r_sign  <= 1'b0;
      r_we    <= 1'b0;
      r_split <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_n     <= w_n_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_asm   <= w_asm_nxt;
      r_size  <= w_size_nxt;
      r_sign  <= w_sign_nxt;
      r_we    <= w_we_nxt;
      r_split <= w_split_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Output registers, loaded with the values belonging to the next state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_mem_rden2 <= 1'b0;
      r_mem_we2   <= 1'b0;
      r_mem_addr2 <= 32'd0;
      r_mem_din2  <= 32'd0;
      r_mem_size  <= 2'd0;
      r_mem_sign  <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= w_done_nxt;
      r_rsp_err   <= w_done_nxt && w_err_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_mem_rden2 <= (w_state_nxt == ISSUE) && !w_we_nxt;
      r_mem_we2   <= (w_state_nxt == ISSUE) && w_we_nxt;
      r_mem_addr2 <= w_mem_addr_nxt;
      r_mem_din2  <= w_mem_din_nxt;
      r_mem_size  <= w_mem_size_nxt;
      r_mem_sign  <= w_mem_sign_nxt;
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_data  = r_rsp_data;
  assign o_mem_rden2 = r_mem_rden2;
  assign o_mem_we2   = r_mem_we2;
  assign o_mem_addr2 = r_mem_addr2;
  assign o_mem_din2  = r_mem_din2;
  assign o_mem_size  = r_mem_size;
  assign o_mem_sign  = r_mem_sign;

endmodule
